// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes the operands
// LSB-first, one bit per clock, with a registered carry between bits.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  assign fa_s     = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign fa_co    = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          a_next     = a;
          // Subtraction is a + ~b + 1: invert B and force the carry-in.
          b_next     = sub ? ~b : b;
          carry_next = sub ? 1'b1 : cin;
          cnt_next   = '0;
          sum_next   = '0;
        end
      end

      RUN: begin
        a_next               = a_reg >> 1;
        b_next               = b_reg >> 1;
        sum_next             = sum_reg >> 1;
        sum_next[WIDTH-1]    = fa_s;
        carry_next           = fa_co;
        if (last_bit) begin
          // Hold the counter on the final bit so it never wraps.
          state_next = DONE;
          cout_next  = fa_co;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table at WIDTH=8, hand-written
// corner sequences, random ops, and an exhaustive back-to-back run at WIDTH=3.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start3, sub3, cin3;
  logic [2:0] a3, b3;
  logic       busy3, done3, cout3;
  logic [2:0] sum3;

  int checks;
  int errors;
  int dones3;
  logic [3:0] exp3_q[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .sub(sub3), .a(a3), .b(b3),
    .cin(cin3), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: {cout,sum} as a (w+1)-bit integer result.
  function automatic longint unsigned ref_fn(input longint unsigned a, input longint unsigned b,
                                             input logic cin, input logic sub, input int w);
    longint unsigned m;
    longint unsigned r;
    m = (64'd1 << w) - 1;
    if (sub) r = a + ((~b) & m) + 1;
    else     r = a + b + cin;
    return r & ((m << 1) | 1);
  endfunction

  // One WIDTH=8 operation starting at a negedge, observed for 12 cycles.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic disturb,
                         output logic [7:0] rs, output logic rc);
    rs = '0;
    rc = 1'b0;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int idx = 1; idx <= 12; idx++) begin
      @(negedge clk);
      if (disturb) begin
        if (idx == 3) begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1; sub8 = 1'b1; end
        if (idx == 4) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
        if (idx == 5) start8 = 1'b0;
      end
      check($sformatf("busy8[%0d]", idx), 32'(busy8), 32'(idx <= 9));
      check($sformatf("done8[%0d]", idx), 32'(done8), 32'(idx == 9));
      if (idx == 9) begin
        rs = sum8;
        rc = cout8;
      end else if (idx > 9) begin
        check($sformatf("sum8_hold[%0d]", idx), 32'(sum8), 32'(rs));
        check($sformatf("cout8_hold[%0d]", idx), 32'(cout8), 32'(rc));
      end
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  // WIDTH=3 result monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done3) begin
      dones3++;
      if (exp3_q.size() == 0) begin
        check("done3_unexpected", 32'(1), 32'(0));
      end else begin
        check($sformatf("res3[%0d]", dones3), 32'({cout3, sum3}), 32'(exp3_q.pop_front()));
      end
    end
  end

  initial begin
    vec_t       vecs[8];
    logic [7:0] rs;
    logic       rc;
    logic [7:0] ra, rb;
    logic       rcin, rsub;
    longint unsigned e;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1};
    vecs[2] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
    vecs[3] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1};

    checks = 0; errors = 0; dones3 = 0;
    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start3 = 1'b0; sub3 = 1'b0; cin3 = 1'b0; a3 = '0; b3 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy8), 32'(0));
    check("reset_done", 32'(done8), 32'(0));
    check("reset_sum", 32'(sum8), 32'(0));
    check("reset_cout", 32'(cout8), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0, rs, rc);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].exp_cout));
      $display("vec %0d a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc);
    end

    // Inputs changed mid-operation and a start pulse during RUN are ignored.
    run_op8(8'h11, 8'h22, 1'b0, 1'b0, 1'b1, rs, rc);
    check("disturb_sum", 32'(rs), 32'h33);
    check("disturb_cout", 32'(rc), 32'(0));
    $display("disturb a=11 b=22 -> sum=%02h cout=%0d", rs, rc);

    // Asynchronous reset in the middle of an operation.
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", 32'(busy8), 32'(1));
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'(0));
    check("abort_done", 32'(done8), 32'(0));
    check("abort_sum", 32'(sum8), 32'(0));
    check("abort_cout", 32'(cout8), 32'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      check($sformatf("abort_nodone[%0d]", i), 32'(done8), 32'(0));
    end
    run_op8(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, rs, rc);
    check("post_reset_sum", 32'(rs), 32'h02);
    check("post_reset_cout", 32'(rc), 32'(0));
    $display("post-reset 01+01 -> sum=%02h cout=%0d", rs, rc);

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rcin = 1'($urandom); rsub = 1'($urandom);
      e = ref_fn(ra, rb, rcin, rsub, 8);
      run_op8(ra, rb, rcin, rsub, 1'b0, rs, rc);
      check($sformatf("rand%0d", i), 32'({rc, rs}), 32'(e));
      $display("rand %0d a=%02h b=%02h cin=%0d sub=%0d -> %03h exp %03h",
               i, ra, rb, rcin, rsub, {rc, rs}, e[8:0]);
    end

    // WIDTH=3 exhaustive, start held high for back-to-back operations.
    for (int op = 0; op < 256; op++) begin
      @(negedge clk);
      a3 = 3'(op); b3 = 3'(op >> 3); cin3 = 1'(op >> 6); sub3 = 1'(op >> 7);
      start3 = 1'b1;
      exp3_q.push_back(4'(ref_fn(a3, b3, cin3, sub3, 3)));
      @(posedge clk);
      #1;
      a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom); sub3 = 1'($urandom);
      repeat (4) @(posedge clk);
    end
    start3 = 1'b0;
    repeat (8) @(negedge clk);
    check("w3_done_count", 32'(dones3), 32'd256);
    check("w3_queue_empty", 32'(exp3_q.size()), 32'(0));
    check("w3_idle", 32'(busy3), 32'(0));
    $display("w3 exhaustive: %0d done pulses", dones3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
